pc_update: RTL and testbench
============================

PC_UPDATE -- requirements
Module: pc_update

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, value loaded into pc_q on reset.
REQ-002 Parameter ALIGN_CHECK, default 1, enables the misaligned flag; when 0, misaligned SHALL be tied 0.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port pc_address  input  32  PC of the current instruction.
REQ-006 Port rs1_data  input  32  rs1 register value (JALR base).
REQ-007 Port imm  input  32  sign-extended immediate, two's complement.
REQ-008 Port jump  input  1  unconditional jump (JAL or JALR).
REQ-009 Port jalr_enable  input  1  with jump, selects JALR target.
REQ-010 Port branch  input  1  conditional branch instruction.
REQ-011 Port zero  input  1  branch condition met (from ALU compare).
REQ-012 Port stall  input  1  holds pc_q when high.
REQ-013 Port next_pc  output  32  combinational next PC.
REQ-014 Port pc_q  output  32  registered PC.
REQ-015 Port redirect  output  1  high when next_pc is not the sequential PC+4.
REQ-016 Port misaligned  output  1  next_pc[1:0] != 2'b00 (gated by ALIGN_CHECK).

Function
REQ-017 next_pc, redirect and misaligned SHALL be purely combinational from inputs, zero-cycle latency, independent of clk, rst and stall.
REQ-018 Selection priority SHALL be: JALR (jump=1, jalr_enable=1) > JAL (jump=1, jalr_enable=0) > taken branch (branch=1, zero=1) > sequential.
REQ-019 JALR: next_pc SHALL be (rs1_data + imm) with bit 0 cleared; pc_address, branch and zero ignored.
REQ-020 JAL: next_pc SHALL be pc_address + imm; branch, zero, rs1_data ignored.
REQ-021 Taken branch: next_pc SHALL be pc_address + imm.
REQ-022 Sequential (all other cases, including branch=1 with zero=0): next_pc SHALL be pc_address + 4.
REQ-023 jalr_enable=1 with jump=0 SHALL be ignored (treated as jalr_enable=0).
REQ-024 All additions SHALL be 32-bit modulo 2^32; carry-out discarded (0xFFFFFFFC+4 = 0x00000000; negative imm subtracts).
REQ-025 redirect SHALL be 1 for JALR, JAL and taken branch, else 0.
REQ-026 On each rising clk with rst=0 and stall=0, pc_q SHALL load next_pc; with stall=1, pc_q SHALL hold.
REQ-027 pc_q SHALL change only on a rising clk edge.

Reset
REQ-028 On a rising clk with rst=1, pc_q SHALL load RESET_PC regardless of stall and all other inputs.
REQ-029 rst SHALL have no effect on the combinational outputs.
REQ-030 Reset asserted mid-operation SHALL take effect at the next rising edge; the first edge after deassertion resumes loading next_pc.

Verification
REQ-031 Sequential: pc_address=0x00000000, jump=branch=0 -> next_pc=0x00000004, redirect=0; pc_address=0xFFFFFFFC -> next_pc=0x00000000.
REQ-032 JALR: jump=jalr_enable=1, rs1_data=0x1000, imm=0x20 -> next_pc=0x00001020; rs1_data=0x2000, imm=0xFFFFFFF0 -> 0x00001FF0; rs1_data=0x1001, imm=0 -> 0x00001000.
REQ-033 JAL: pc_address=0x80, imm=0x100 -> next_pc=0x00000180; pc_address=0x200, imm=0xFFFFFE00 -> 0x00000000.
REQ-034 Branch: pc_address=0x400, imm=0x40, branch=zero=1 -> 0x00000440, redirect=1; pc_address=0x800, zero=0 -> 0x00000804, redirect=0.
REQ-035 Priority: jump=jalr_enable=branch=zero=1, rs1_data=0x2000, imm=0x10 -> 0x00002010; jalr_enable=0, pc_address=0x3000, imm=0x20 -> 0x00003020.
REQ-036 Sequencing: rst=1 one edge -> pc_q=RESET_PC; stall=1 holds pc_q; pc_address=0x4 after stall release -> pc_q=0x00000008 after the next edge; imm=0x2 JAL from 0x0 -> misaligned=1.

Source files
------------

// File: rtl/pc_update.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_update : next-PC selection (JALR / JAL / taken branch / PC+4) and PC reg
// Revision  : 1.0
// ----------------------------------------------------------------------------
module pc_update #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_address,
  input  logic [31:0] rs1_data,
  input  logic [31:0] imm,
  input  logic        jump,
  input  logic        jalr_enable,
  input  logic        branch,
  input  logic        zero,
  input  logic        stall,
  output logic [31:0] next_pc,
  output logic [31:0] pc_q,
  output logic        redirect,
  output logic        misaligned
);

  logic [31:0] w_seq_pc;
  logic [31:0] w_rel_pc;
  logic [31:0] w_jalr_sum;
  logic [31:0] r_pc;

  assign w_seq_pc   = pc_address + 32'd4;
  assign w_rel_pc   = pc_address + imm;
  assign w_jalr_sum = rs1_data + imm;

  // jalr_enable only matters together with jump
  always_comb begin
    next_pc  = w_seq_pc;
    redirect = 1'b0;
    if (jump && jalr_enable) begin
      next_pc  = {w_jalr_sum[31:1], 1'b0};
      redirect = 1'b1;
    end else if (jump) begin
      next_pc  = w_rel_pc;
      redirect = 1'b1;
    end else if (branch && zero) begin
      next_pc  = w_rel_pc;
      redirect = 1'b1;
    end
  end

  generate
    if (ALIGN_CHECK != 0) begin : g_align_on
      assign misaligned = |next_pc[1:0];
    end else begin : g_align_off
      assign misaligned = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (!stall) begin
      r_pc <= next_pc;
    end
  end

  assign pc_q = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_pc_update.sv
`default_nettype none
// tb_pc_update : directed self-checking bench for pc_update
module tb_pc_update;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic [31:0] pc_address;
  logic [31:0] rs1_data;
  logic [31:0] imm;
  logic        jump;
  logic        jalr_enable;
  logic        branch;
  logic        zero;
  logic        stall;
  logic [31:0] next_pc;
  logic [31:0] pc_q;
  logic        redirect;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  pc_update #(
    .RESET_PC    (C_RESET_PC),
    .ALIGN_CHECK (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_address  (pc_address),
    .rs1_data    (rs1_data),
    .imm         (imm),
    .jump        (jump),
    .jalr_enable (jalr_enable),
    .branch      (branch),
    .zero        (zero),
    .stall       (stall),
    .next_pc     (next_pc),
    .pc_q        (pc_q),
    .redirect    (redirect),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] im,
                       input logic j, input logic je, input logic b, input logic z);
    pc_address  = pc;
    rs1_data    = rs1;
    imm         = im;
    jump        = j;
    jalr_enable = je;
    branch      = b;
    zero        = z;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b1;
    drive(32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset wins over stall
    tick();
    chk32("reset_pc_q", pc_q, 32'h0000_0100);

    // combinational outputs are live while rst is high
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk32("seq_in_reset_next_pc", next_pc, 32'h0000_0004);
    chk1 ("seq_in_reset_redirect", redirect, 1'b0);
    chk1 ("seq_in_reset_misaligned", misaligned, 1'b0);

    rst = 1'b0;
    drive(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk32("seq_wrap", next_pc, 32'h0000_0000);

    drive(32'h0, 32'h1000, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0);
    chk32("jalr_pos", next_pc, 32'h0000_1020);
    chk1 ("jalr_redirect", redirect, 1'b1);
    drive(32'h0, 32'h2000, 32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk32("jalr_neg", next_pc, 32'h0000_1FF0);
    drive(32'h0, 32'h1001, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk32("jalr_bit0_clear", next_pc, 32'h0000_1000);
    chk1 ("jalr_bit0_aligned", misaligned, 1'b0);
    drive(32'h0, 32'h1000, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0);
    chk32("jalr_bit1_kept", next_pc, 32'h0000_1002);
    chk1 ("jalr_bit1_misaligned", misaligned, 1'b1);

    drive(32'h80, 32'h5555, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
    chk32("jal_pos", next_pc, 32'h0000_0180);
    chk1 ("jal_redirect", redirect, 1'b1);
    drive(32'h200, 32'h5555, 32'hFFFF_FE00, 1'b1, 1'b0, 1'b1, 1'b0);
    chk32("jal_neg", next_pc, 32'h0000_0000);

    drive(32'h400, 32'h0, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1);
    chk32("branch_taken", next_pc, 32'h0000_0440);
    chk1 ("branch_taken_redirect", redirect, 1'b1);
    drive(32'h800, 32'h0, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0);
    chk32("branch_not_taken", next_pc, 32'h0000_0804);
    chk1 ("branch_not_taken_redirect", redirect, 1'b0);
    drive(32'h600, 32'h0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
    chk32("zero_without_branch", next_pc, 32'h0000_0604);

    drive(32'h3000, 32'h2000, 32'h10, 1'b1, 1'b1, 1'b1, 1'b1);
    chk32("prio_jalr", next_pc, 32'h0000_2010);
    drive(32'h3000, 32'h2000, 32'h20, 1'b1, 1'b0, 1'b1, 1'b1);
    chk32("prio_jal", next_pc, 32'h0000_3020);
    drive(32'h500, 32'h9000, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0);
    chk32("jalr_en_no_jump", next_pc, 32'h0000_0504);
    chk1 ("jalr_en_no_jump_redirect", redirect, 1'b0);
    drive(32'h500, 32'h9000, 32'h8, 1'b0, 1'b1, 1'b1, 1'b1);
    chk32("jalr_en_no_jump_branch", next_pc, 32'h0000_0508);

    drive(32'h0, 32'h0, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk32("jal_misaligned_pc", next_pc, 32'h0000_0002);
    chk1 ("jal_misaligned", misaligned, 1'b1);

    // pc_q held since reset because stall stayed high
    chk32("hold_no_edge", pc_q, 32'h0000_0100);
    drive(32'h4, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk32("stall_hold", pc_q, 32'h0000_0100);

    stall = 1'b0;
    tick();
    chk32("load_seq", pc_q, 32'h0000_0008);

    drive(32'h8, 32'h0, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    chk32("between_edges", pc_q, 32'h0000_0008);
    tick();
    chk32("load_jal", pc_q, 32'h0000_0018);

    drive(32'h18, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk32("rst_not_async", pc_q, 32'h0000_0018);
    tick();
    chk32("mid_reset", pc_q, 32'h0000_0100);

    rst = 1'b0;
    drive(32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk32("resume_after_reset", pc_q, 32'h0000_0104);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
